// File: rtl/rand_pkt_gen.sv
// rand_pkt_gen -- random-length packet generator.
//
// Builds packets from an upstream pseudo-random byte stream. Each packet is
// one header word {dest[3:0], seq[11:0], len[15:0]} followed by len payload
// words taken from a 32-bit shift register fed with i_rand_byte every cycle.
// Runs are started with i_start and last i_pkt_num packets (0 = continuous,
// ended by i_stop after the packet in flight).
//
// Optional feature: define RAND_PKT_GEN_CHKSUM_EN to append one trailer word
// (XOR of all payload words) that carries o_eop instead of the last payload.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   i_rand_byte[7:0]    random byte, new value every cycle
//   i_start, i_stop     run start pulse / stop-after-current-packet pulse
//   i_pkt_num[15:0]     packets per run, 0 = continuous (latched at start)
//   i_gap[7:0]          idle cycles between packets (latched at start)
//   i_ready             downstream accepts the presented word
//   o_valid, o_data     output word and its qualifier
//   o_sop, o_eop        header word / last word markers
//   o_busy, o_done      run active / one-cycle end-of-run pulse
//   o_pkt_cnt[15:0]     packets completed in the current (or last) run
module rand_pkt_gen #(
    parameter int unsigned MIN_WORDS = 16,
    parameter int unsigned LEN_BITS  = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  i_rand_byte,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic [15:0] i_pkt_num,
    input  logic [7:0]  i_gap,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [31:0] o_data,
    output logic        o_sop,
    output logic        o_eop,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_pkt_cnt
);

`ifdef RAND_PKT_GEN_CHKSUM_EN
    localparam logic [16:0] TRAILER_WORDS = 17'd1;
`else
    localparam logic [16:0] TRAILER_WORDS = 17'd0;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, HDR, DATA, GAP, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] sr_q, sr_d;
    logic [31:0] data_q, data_d;
    logic        sop_q, sop_d;
    logic        eop_q, eop_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] pkt_num_q, pkt_num_d;
    logic [7:0]  gap_q, gap_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic [16:0] total_q, total_d;     // words after the header (payload + trailer)
    logic [16:0] loaded_q, loaded_d;   // words after the header loaded so far
    logic [31:0] chk_q, chk_d;
    logic        stop_q, stop_d;

    logic [15:0] len_w;
    logic [16:0] next_idx;
    logic        next_is_trailer;
    logic        last_pkt;
    logic        xfer;

    assign o_valid   = (state_q == HDR) || (state_q == DATA);
    assign o_data    = data_q;
    assign o_sop     = sop_q;
    assign o_eop     = eop_q;
    assign o_busy    = (state_q != IDLE);
    assign o_done    = (state_q == DONE);
    assign o_pkt_cnt = cnt_q;

    always_comb begin
        state_d   = state_q;
        sr_d      = {sr_q[23:0], i_rand_byte};
        data_d    = data_q;
        sop_d     = sop_q;
        eop_d     = eop_q;
        cnt_d     = cnt_q;
        pkt_num_d = pkt_num_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        total_d   = total_q;
        loaded_d  = loaded_q;
        chk_d     = chk_q;
        stop_d    = stop_q;

        xfer            = o_valid && i_ready;
        len_w           = 16'(MIN_WORDS) + 16'(i_rand_byte[LEN_BITS-1:0]);
        next_idx        = loaded_q + 17'd1;
        next_is_trailer = (TRAILER_WORDS != '0) && (next_idx == total_q);
        // i_stop arriving on the eop edge itself still ends the run.
        last_pkt        = ((pkt_num_q != '0) && ((cnt_q + 16'd1) == pkt_num_q))
                          || stop_q || i_stop;

        if ((state_q != IDLE) && i_stop) begin
            stop_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d   = LOAD;
                    pkt_num_d = i_pkt_num;
                    gap_d     = i_gap;
                    cnt_d     = '0;
                    stop_d    = 1'b0;
                end
            end
            LOAD: begin
                data_d   = {i_rand_byte[7:4], cnt_q[11:0], len_w};
                sop_d    = 1'b1;
                eop_d    = 1'b0;
                total_d  = {1'b0, len_w} + TRAILER_WORDS;
                loaded_d = '0;
                chk_d    = '0;
                state_d  = HDR;
            end
            HDR, DATA: begin
                if (xfer) begin
                    sop_d = 1'b0;
                    if (eop_q) begin
                        eop_d = 1'b0;
                        cnt_d = cnt_q + 16'd1;
                        if (last_pkt) begin
                            state_d = DONE;
                        end else if (gap_q != '0) begin
                            state_d   = GAP;
                            gap_cnt_d = gap_q;
                        end else begin
                            state_d = LOAD;
                        end
                    end else begin
                        // The output register is the only word buffer, so the
                        // next word is captured on the edge that consumes this one.
                        state_d  = DATA;
                        data_d   = next_is_trailer ? chk_q : sr_q;
                        chk_d    = chk_q ^ sr_q;
                        eop_d    = (next_idx == total_q);
                        loaded_d = next_idx;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == 8'd1) begin
                    state_d = LOAD;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            DONE: begin
                stop_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            data_q    <= '0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            cnt_q     <= '0;
            pkt_num_q <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            total_q   <= '0;
            loaded_q  <= '0;
            chk_q     <= '0;
            stop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            data_q    <= data_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
            cnt_q     <= cnt_d;
            pkt_num_q <= pkt_num_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            total_q   <= total_d;
            loaded_q  <= loaded_d;
            chk_q     <= chk_d;
            stop_q    <= stop_d;
        end
    end

endmodule

// File: tb/tb_rand_pkt_gen.sv
module tb_rand_pkt_gen;
    localparam int MIN_W = 16;
    localparam int LB    = 6;
`ifdef RAND_PKT_GEN_CHKSUM_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  i_rand_byte;
    logic        i_start, i_stop, i_ready;
    logic [15:0] i_pkt_num;
    logic [7:0]  i_gap;
    logic        o_valid, o_sop, o_eop, o_busy, o_done;
    logic [31:0] o_data;
    logic [15:0] o_pkt_cnt;

    rand_pkt_gen #(.MIN_WORDS(MIN_W), .LEN_BITS(LB)) dut (
        .clk(clk), .rst_n(rst_n), .i_rand_byte(i_rand_byte), .i_start(i_start),
        .i_stop(i_stop), .i_pkt_num(i_pkt_num), .i_gap(i_gap), .i_ready(i_ready),
        .o_valid(o_valid), .o_data(o_data), .o_sop(o_sop), .o_eop(o_eop),
        .o_busy(o_busy), .o_done(o_done), .o_pkt_cnt(o_pkt_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] bh [0:131071];   // byte sampled at each rising edge (0 while in reset)
    logic rdy_rand = 1'b0;

    // Reference model state
    logic        busy_m = 1'b0, done_exp = 1'b0, stop_m = 1'b0, first_m = 1'b0;
    logic        prev_stall = 1'b0, prev_sop = 1'b0, prev_eop = 1'b0;
    logic [31:0] prev_d = '0, exp_word = '0, xor_m = '0, last_hdr = '0;
    logic [15:0] cnt_m = '0, pktnum_m = '0;
    logic [7:0]  gap_m = '0;
    int          w_idx = -1, tot_m = 0, inv_cnt = 0, last_gap = 0, last_words = 0, done_cnt = 0;
    int          seq_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] byte_at(input int k);
        if (k < 1 || k > 131071) return 8'h00;
        return bh[k];
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (cyc <= 131071) bh[cyc] = rst_n ? i_rand_byte : 8'h00;
    end

    // Compare process: outputs after edge 'cyc' against the model, then advance
    // the model using the inputs that the next edge will sample.
    always @(negedge clk) begin
        logic [7:0]  hb;
        logic [15:0] hdr_len;
        if (!rst_n) begin
            chk("rst_valid", 32'(o_valid), 0);
            chk("rst_sop_eop", {30'b0, o_sop, o_eop}, 0);
            chk("rst_data", o_data, 0);
            chk("rst_busy_done", {30'b0, o_busy, o_done}, 0);
            chk("rst_pkt_cnt", 32'(o_pkt_cnt), 0);
            busy_m = 0; done_exp = 0; cnt_m = 0; stop_m = 0; prev_stall = 0; w_idx = -1;
        end else begin
            chk("busy", 32'(o_busy), 32'(busy_m));
            chk("done", 32'(o_done), 32'(done_exp));
            chk("pkt_cnt", 32'(o_pkt_cnt), 32'(cnt_m));
            if (!busy_m) chk("idle_valid", 32'(o_valid), 0);
            if (prev_stall) begin
                chk("stall_valid", 32'(o_valid), 1);
                chk("stall_data", o_data, prev_d);
                chk("stall_flags", {30'b0, o_sop, o_eop}, {30'b0, prev_sop, prev_eop});
            end
            if (o_valid && busy_m && w_idx < 0) begin
                hb = byte_at(cyc);
                hdr_len = 16'(MIN_W) + 16'(hb & 8'((1 << LB) - 1));
                chk("hdr_dest", 32'(o_data[31:28]), 32'(hb[7:4]));
                chk("hdr_seq", 32'(o_data[27:16]), 32'(cnt_m[11:0]));
                chk("hdr_len", 32'(o_data[15:0]), 32'(hdr_len));
                chk("hdr_idle_cycles", inv_cnt, first_m ? 1 : int'(gap_m) + 1);
                seq_q.push_back(int'(o_data[27:16]));
                last_hdr = o_data; last_gap = inv_cnt; first_m = 0;
                tot_m = int'(hdr_len) + CHK; w_idx = 0; xor_m = '0;
            end
            if (!o_valid && busy_m) inv_cnt++;
            if (o_valid && w_idx >= 0) begin
                chk("sop", 32'(o_sop), 32'(w_idx == 0));
                chk("eop", 32'(o_eop), 32'(w_idx == tot_m));
                if (w_idx > 0) chk((CHK == 1 && w_idx == tot_m) ? "trailer" : "payload", o_data, exp_word);
            end

            if (busy_m && !done_exp && i_stop) stop_m = 1;
            if (done_exp) begin
                busy_m = 0; done_exp = 0; done_cnt++;
            end else if (!busy_m && i_start) begin
                busy_m = 1; cnt_m = 0; pktnum_m = i_pkt_num; gap_m = i_gap;
                stop_m = 0; first_m = 1; inv_cnt = 0;
            end
            if (o_valid && i_ready && w_idx >= 0) begin
                if (w_idx == tot_m) begin
                    cnt_m = cnt_m + 16'd1; last_words = w_idx; w_idx = -1; inv_cnt = 0;
                    if ((pktnum_m != 0 && cnt_m == pktnum_m) || stop_m) done_exp = 1;
                end else begin
                    w_idx++;
                    if (CHK == 1 && w_idx == tot_m) exp_word = xor_m;
                    else begin
                        exp_word = {byte_at(cyc-3), byte_at(cyc-2), byte_at(cyc-1), byte_at(cyc)};
                        xor_m = xor_m ^ exp_word;
                    end
                end
            end
            prev_stall = o_valid && !i_ready;
            prev_d = o_data; prev_sop = o_sop; prev_eop = o_eop;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        i_rand_byte = 8'($urandom);
        i_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        i_start = 1'b0;
        i_stop = 1'b0;
    endtask

    task automatic start_run(input logic [15:0] pn, input logic [7:0] gp);
        i_pkt_num = pn; i_gap = gp; i_start = 1'b1;
        tick();
    endtask

    task automatic wait_done(input string nm, input int budget);
        int d0 = done_cnt;
        int k = 0;
        while (done_cnt == d0 && k < budget) begin tick(); k++; end
        if (done_cnt == d0) begin
            checks++; errors++;
            $display("FAIL %s: no o_done within %0d cycles", nm, budget);
        end
        repeat (3) tick();
    endtask

    initial begin
        int d0, k;
        i_rand_byte = 0; i_start = 0; i_stop = 0; i_pkt_num = 0; i_gap = 0; i_ready = 1;
        rst_n = 1'b0;
        repeat (5) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_reset_busy", 32'(o_busy), 0);
        chk("post_reset_cnt", 32'(o_pkt_cnt), 0);

        // i_stop while idle must not affect anything; then 3 back-to-back packets
        i_stop = 1'b1; tick();
        seq_q.delete(); d0 = done_cnt;
        start_run(16'd3, 8'd0);
        wait_done("run3", 3000);
        chk("run3_cnt", 32'(o_pkt_cnt), 3);
        chk("run3_done_pulses", done_cnt - d0, 1);
        chk("run3_npkts", seq_q.size(), 3);
        if (seq_q.size() == 3) begin
            chk("run3_seq0", seq_q[0], 0);
            chk("run3_seq1", seq_q[1], 1);
            chk("run3_seq2", seq_q[2], 2);
        end

        // Fixed length byte in the LOAD cycle
        start_run(16'd1, 8'd0);
        i_rand_byte = 8'hA7;
        tick();
        wait_done("a7", 2000);
        chk("a7_dest", 32'(last_hdr[31:28]), 32'h0000000A);
        chk("a7_len", 32'(last_hdr[15:0]), 55);
        chk("a7_words", last_words, 55 + CHK);

        // Random backpressure, plus a start pulse during the run that must be ignored
        rdy_rand = 1'b1;
        start_run(16'd4, 8'($urandom_range(0, 3)));
        repeat (20) tick();
        i_start = 1'b1; tick();
        wait_done("rand_ready", 8000);
        chk("rand_ready_cnt", 32'(o_pkt_cnt), 4);

        // Continuous run stopped in the middle of packet 2
        seq_q.delete();
        start_run(16'd0, 8'd2);
        k = 0;
        while (!(cnt_m == 16'd1 && w_idx >= 3) && k < 4000) begin tick(); k++; end
        if (k >= 4000) begin checks++; errors++; $display("FAIL stop_wait: packet 2 not reached"); end
        i_stop = 1'b1; tick();
        wait_done("stop", 4000);
        chk("stop_cnt", 32'(o_pkt_cnt), 2);
        chk("stop_npkts", seq_q.size(), 2);

        // Gap of 5 idle cycles
        rdy_rand = 1'b0;
        start_run(16'd2, 8'd5);
        wait_done("gap5", 2000);
        chk("gap5_idle_cycles", last_gap, 6);
        chk("gap5_cnt", 32'(o_pkt_cnt), 2);

        // Reset in the middle of a payload
        start_run(16'd0, 8'd0);
        k = 0;
        while (!(o_valid && w_idx >= 5) && k < 2000) begin tick(); k++; end
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(o_valid), 0);
        chk("abort_busy", 32'(o_busy), 0);
        repeat (5) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("post_abort_busy", 32'(o_busy), 0);
        chk("post_abort_valid", 32'(o_valid), 0);

        // Recovery run after the abort
        rdy_rand = 1'b1;
        start_run(16'd2, 8'd1);
        wait_done("recover", 4000);
        chk("recover_cnt", 32'(o_pkt_cnt), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rand_pkt_gen.md
RAND_PKT_GEN -- requirements
Module: rand_pkt_gen

Interface
REQ-001 SHALL have parameter MIN_WORDS, default 16: minimum payload length in 32-bit words.
REQ-002 SHALL have parameter LEN_BITS, default 6: number of random bits added to MIN_WORDS.
REQ-003 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port i_rand_byte, input, 8: pseudo-random byte from the upstream byte generator, new value every cycle.
REQ-006 SHALL have port i_start, input, 1: pulse that begins a run.
REQ-007 SHALL have port i_stop, input, 1: pulse that ends a continuous run after the current packet.
REQ-008 SHALL have port i_pkt_num, input, 16: packets per run; 0 means continuous.
REQ-009 SHALL have port i_gap, input, 8: idle cycles between packets.
REQ-010 SHALL have port i_ready, input, 1: downstream accepts the word.
REQ-011 SHALL have port o_valid, input-qualified output, 1: o_data valid.
REQ-012 SHALL have ports o_data (output, 32), o_sop (output, 1, header word) and o_eop (output, 1, last word).
REQ-013 SHALL have ports o_busy (output, 1), o_done (output, 1-cycle pulse) and o_pkt_cnt (output, 16, packets completed this run).

Function
REQ-014 SHALL shift i_rand_byte into a 32-bit register SR every cycle, including while idle: SR <= {SR[23:0], i_rand_byte}.
REQ-015 SHALL use FSM states IDLE, LOAD, HDR, DATA, GAP and DONE.
REQ-016 IDLE->LOAD on i_start; i_pkt_num and i_gap SHALL be latched at that point; o_pkt_cnt SHALL clear to 0.
REQ-017 LOAD SHALL last 1 cycle with o_valid=0, capture dest=i_rand_byte[7:4] and len=MIN_WORDS+i_rand_byte[LEN_BITS-1:0], then go to HDR.
REQ-018 HDR SHALL present o_data={dest[3:0], seq[11:0], len[15:0]} with o_sop=1; seq is o_pkt_cnt[11:0].
REQ-019 DATA SHALL present len payload words; each word is the value of SR in the cycle it is loaded into the output register.
REQ-020 A word is loaded on entering HDR->DATA and after each accepted payload word.
REQ-021 A transfer SHALL occur only when o_valid && i_ready; while o_valid && !i_ready, o_data, o_sop and o_eop SHALL hold stable.
REQ-022 o_eop SHALL be 1 on the final word of the packet only.
REQ-023 On eop transfer, o_pkt_cnt SHALL increment, wrapping from 0xFFFF to 0.
REQ-024 After eop transfer, the next state SHALL be DONE if (i_pkt_num!=0 and o_pkt_cnt reached i_pkt_num) or a stop is pending.
REQ-025 Otherwise, after eop transfer, the next state SHALL be GAP if i_gap!=0, else LOAD.
REQ-026 GAP SHALL hold o_valid=0 for exactly i_gap cycles, then go to LOAD.
REQ-027 i_stop SHALL set a pending flag; a packet in flight always completes. i_stop in IDLE SHALL be ignored. i_start while busy SHALL be ignored.
REQ-028 DONE SHALL assert o_done for 1 cycle, then go to IDLE; o_busy SHALL be 1 in every state except IDLE.
REQ-029 o_pkt_cnt SHALL hold its value in IDLE until the next i_start.

Reset
REQ-030 While rst_n=0: state=IDLE, SR=0, o_valid=0, o_sop=0, o_eop=0, o_data=0, o_busy=0, o_done=0, o_pkt_cnt=0, stop flag clear.
REQ-031 Reset mid-packet SHALL abort the packet immediately with no eop emitted; after release, the block SHALL stay IDLE until i_start.

Configuration
REQ-032 With macro RAND_PKT_GEN_CHKSUM_EN defined, the block SHALL append one trailer word after the payload: the XOR of all payload words, with o_eop moved to the trailer.
REQ-033 With RAND_PKT_GEN_CHKSUM_EN undefined, the block SHALL emit no trailer, and the last payload word SHALL carry o_eop.

Verification
REQ-034 i_pkt_num=3, i_gap=0, i_ready=1 -> 3 packets back-to-back, 1 LOAD idle cycle between them, seq 0,1,2, o_pkt_cnt=3, one o_done pulse.
REQ-035 i_rand_byte=0xA7 in the LOAD cycle (MIN_WORDS=16, LEN_BITS=6) -> header[31:28]=0xA and len=16+39=55, followed by 55 payload words.
REQ-036 i_ready toggled pseudo-randomly -> no word lost or duplicated, outputs stable while stalled, payload matches an SR model.
REQ-037 i_pkt_num=0, i_stop asserted mid-packet 2 -> packet 2 completes with eop, then o_done; no packet 3 header.
REQ-038 i_gap=5 -> exactly 5 o_valid=0 cycles after eop plus 1 LOAD cycle before the next sop; rst_n pulled low mid-DATA -> o_valid=0 immediately, IDLE.
REQ-039 With RAND_PKT_GEN_CHKSUM_EN defined -> len+2 words per packet and trailer = XOR of the payload words.
